// File: rtl/ram16x8_bus_reader_if.sv
// Register-bus connection between the CPU-side bus master and the 16x8 RAM responder.
// The master drives the bus value and the load/drive strobes. The RAM drives read data back.
interface ram16x8_bus_reader_if;
    logic [7:0] bus_in;
    logic       mar_in;
    logic       ram_in;
    logic       ram_out;
    logic [7:0] bus_out;
    logic       bus_oe;

    modport master (
        output bus_in, mar_in, ram_in, ram_out,
        input  bus_out, bus_oe
    );

    modport slave (
        input  bus_in, mar_in, ram_in, ram_out,
        output bus_out, bus_oe
    );
endinterface

// File: rtl/ram16x8_bus_reader.sv
// 16x8 RAM with a 4-bit MAR. It captures bus values on sampled CPU clock steps and drives RAM[MAR] back on request.
// It also accepts debounced manual writes from switches while in programming mode.
module ram16x8_bus_reader #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_clk,
    ram16x8_bus_reader_if.slave  bus,
    input  logic                 prog_mode,
    input  logic [3:0]           prog_addr,
    input  logic [7:0]           prog_data,
    input  logic                 prog_write,
    output logic [3:0]           mar_q,
    output logic [7:0]           ram_q,
    output logic                 prog_mode_led,
    output logic                 err_conflict
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, COUNT, WRITE, WAIT_REL} state_t;

    logic             cpu_clk_p0, cpu_clk_p1, cpu_clk_p2;
    logic             step_p3;
    logic             prog_mode_p0, prog_mode_p1;
    logic             btn_p0, btn_p1;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       mar;
    logic [7:0]       ram [16];
    logic [7:0]       bus_out_r;
    logic             bus_oe_r;
    logic             err_r;

    // Synchronizers and step edge detect. The cpu_clk chain resets high, so a cpu_clk already high at reset release is not seen as a rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_clk_p0   <= 1'b1;
            cpu_clk_p1   <= 1'b1;
            cpu_clk_p2   <= 1'b1;
            step_p3      <= 1'b0;
            prog_mode_p0 <= 1'b0;
            prog_mode_p1 <= 1'b0;
            btn_p0       <= 1'b0;
            btn_p1       <= 1'b0;
        end else begin
            cpu_clk_p0   <= cpu_clk;
            cpu_clk_p1   <= cpu_clk_p0;
            cpu_clk_p2   <= cpu_clk_p1;
            step_p3      <= cpu_clk_p1 & ~cpu_clk_p2;
            prog_mode_p0 <= prog_mode;
            prog_mode_p1 <= prog_mode_p0;
            btn_p0       <= prog_write;
            btn_p1       <= btn_p0;
        end
    end

    // MAR, RAM, bus drive and programming-button FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mar       <= '0;
            bus_oe_r  <= 1'b0;
            bus_out_r <= '0;
            err_r     <= 1'b0;
            for (int i = 0; i < 16; i++) ram[i] <= '0;
        end else begin
            bus_oe_r  <= bus.ram_out & ~prog_mode_p1;
            bus_out_r <= (bus.ram_out & ~prog_mode_p1) ? ram[mar] : 8'h00;
            if (prog_mode_p1) begin
                mar <= prog_addr;
                case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (btn_p1) state <= COUNT;
                    end
                    COUNT: begin
                        if (!btn_p1)              state <= IDLE;
                        else if (cnt == CNT_LAST) state <= WRITE;
                        else                      cnt   <= cnt + 1'b1;
                    end
                    WRITE: begin
                        ram[prog_addr] <= prog_data;
                        state          <= WAIT_REL;
                    end
                    WAIT_REL: begin
                        if (!btn_p1) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else begin
                state <= IDLE;
                if (step_p3) begin
                    // The RAM write uses the MAR value from before this step, even when mar_in loads a new address on the same step.
                    if (bus.mar_in) mar <= bus.bus_in[3:0];
                    if (bus.ram_in && !bus.ram_out) ram[mar] <= bus.bus_in;
                    if (bus.ram_in && bus.ram_out)  err_r    <= 1'b1;
                end
            end
        end
    end

    assign bus.bus_out    = bus_out_r;
    assign bus.bus_oe     = bus_oe_r;
    assign mar_q          = mar;
    assign ram_q          = ram[mar];
    assign prog_mode_led  = prog_mode_p1;
    assign err_conflict   = err_r;
endmodule

// File: tb/tb_ram16x8_bus_reader.sv
// Directed bench for ram16x8_bus_reader. Run-mode steps come from a vector table.
// The reset, bus-latency, programming-button and mode-switch cases are written out as sequences.
module tb_ram16x8_bus_reader;
    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_clk;
    logic       prog_mode;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic       prog_write;
    logic [3:0] mar_q;
    logic [7:0] ram_q;
    logic       prog_mode_led;
    logic       err_conflict;

    int n_chk  = 0;
    int n_fail = 0;

    ram16x8_bus_reader_if bus ();

    ram16x8_bus_reader #(.DEBOUNCE_CYCLES(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_clk       (cpu_clk),
        .bus           (bus.slave),
        .prog_mode     (prog_mode),
        .prog_addr     (prog_addr),
        .prog_data     (prog_data),
        .prog_write    (prog_write),
        .mar_q         (mar_q),
        .ram_q         (ram_q),
        .prog_mode_led (prog_mode_led),
        .err_conflict  (err_conflict)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] bus_in;
        logic       mar_in;
        logic       ram_in;
        logic       ram_out;
        logic [3:0] exp_mar;
        logic [7:0] exp_ram_q;
        logic       exp_err;
        logic       exp_oe;
        logic [7:0] exp_bus;
    } vec_t;

    vec_t vecs [9];

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cpu_pulse();
        clks(2);
        cpu_clk = 1'b1;
        clks(6);
        cpu_clk = 1'b0;
        clks(6);
    endtask

    task automatic clear_bus();
        bus.bus_in  = 8'h00;
        bus.mar_in  = 1'b0;
        bus.ram_in  = 1'b0;
        bus.ram_out = 1'b0;
    endtask

    task automatic run_row(input int i);
        bus.bus_in  = vecs[i].bus_in;
        bus.mar_in  = vecs[i].mar_in;
        bus.ram_in  = vecs[i].ram_in;
        bus.ram_out = vecs[i].ram_out;
        cpu_pulse();
        chk($sformatf("row%0d mar_q", i),        32'(mar_q),        32'(vecs[i].exp_mar));
        chk($sformatf("row%0d ram_q", i),        32'(ram_q),        32'(vecs[i].exp_ram_q));
        chk($sformatf("row%0d err_conflict", i), 32'(err_conflict), 32'(vecs[i].exp_err));
        chk($sformatf("row%0d bus_oe", i),       32'(bus.bus_oe),   32'(vecs[i].exp_oe));
        chk($sformatf("row%0d bus_out", i),      32'(bus.bus_out),  32'(vecs[i].exp_bus));
        clear_bus();
        clks(2);
    endtask

    initial begin
        //          bus_in  mar ram out  mar   ram_q  err oe  bus
        vecs[0] = '{8'hA3, 1, 0, 0, 4'h3, 8'h00, 0, 0, 8'h00};
        vecs[1] = '{8'h5C, 0, 1, 0, 4'h3, 8'h5C, 0, 0, 8'h00};
        vecs[2] = '{8'h07, 1, 1, 0, 4'h7, 8'h00, 0, 0, 8'h00};
        vecs[3] = '{8'hF3, 1, 0, 0, 4'h3, 8'h07, 0, 0, 8'h00};
        vecs[4] = '{8'h3A, 0, 1, 1, 4'h3, 8'h07, 1, 1, 8'h07};
        vecs[5] = '{8'h0F, 1, 0, 0, 4'hF, 8'h00, 1, 0, 8'h00};
        vecs[6] = '{8'h2E, 1, 0, 0, 4'hE, 8'h00, 1, 0, 8'h00};
        vecs[7] = '{8'h03, 1, 0, 0, 4'h3, 8'h00, 0, 0, 8'h00};
        vecs[8] = '{8'h5F, 1, 0, 0, 4'hF, 8'h00, 0, 0, 8'h00};

        rst        = 1'b1;
        cpu_clk    = 1'b1;
        prog_mode  = 1'b0;
        prog_addr  = 4'h0;
        prog_data  = 8'h00;
        prog_write = 1'b0;
        clear_bus();
        bus.bus_in = 8'hA5;
        bus.mar_in = 1'b1;
        clks(3);
        rst = 1'b0;
        clks(10);
        chk("reset mar_q (no spurious step)", 32'(mar_q),         32'h0);
        chk("reset ram_q",                    32'(ram_q),         32'h00);
        chk("reset bus_oe",                   32'(bus.bus_oe),    32'h0);
        chk("reset bus_out",                  32'(bus.bus_out),   32'h00);
        chk("reset err_conflict",             32'(err_conflict),  32'h0);
        chk("reset prog_mode_led",            32'(prog_mode_led), 32'h0);
        clear_bus();
        cpu_clk = 1'b0;
        clks(4);

        for (int i = 0; i < 2; i++) run_row(i);

        // Registered bus drive appears one clk after ram_out
        bus.ram_out = 1'b1;
        #1;
        chk("bus_oe before edge", 32'(bus.bus_oe), 32'h0);
        clks(1);
        chk("bus_oe one clk after ram_out", 32'(bus.bus_oe),  32'h1);
        chk("bus_out drives RAM[3]",        32'(bus.bus_out), 32'h5C);
        bus.ram_out = 1'b0;
        clks(1);
        chk("bus_oe released",  32'(bus.bus_oe),  32'h0);
        chk("bus_out released", 32'(bus.bus_out), 32'h00);

        for (int i = 2; i < 7; i++) run_row(i);

        // Programming mode: debounced single write to RAM[15]
        prog_mode = 1'b1;
        prog_addr = 4'hF;
        prog_data = 8'h99;
        clks(4);
        chk("prog_mode_led", 32'(prog_mode_led), 32'h1);
        chk("prog mar tracks prog_addr", 32'(mar_q), 32'hF);
        chk("prog RAM[15] initially 0", 32'(ram_q), 32'h00);
        bus.ram_out = 1'b1;
        clks(2);
        chk("prog bus_oe held low",  32'(bus.bus_oe),  32'h0);
        chk("prog bus_out held low", 32'(bus.bus_out), 32'h00);
        bus.ram_out = 1'b0;
        repeat (3) begin
            prog_write = 1'b1;
            clks(1);
            prog_write = 1'b0;
            clks(1);
        end
        clks(4);
        chk("bounce causes no write", 32'(ram_q), 32'h00);
        prog_write = 1'b1;
        clks(20);
        chk("held press writes RAM[15]", 32'(ram_q), 32'h99);
        prog_data = 8'h11;
        clks(20);
        chk("holding does not repeat write", 32'(ram_q), 32'h99);
        prog_write = 1'b0;
        clks(4);

        // Steps ignored in prog mode; leaving prog mode mid-press aborts the write
        prog_addr   = 4'h2;
        prog_data   = 8'h42;
        bus.bus_in  = 8'h09;
        bus.mar_in  = 1'b1;
        bus.ram_in  = 1'b1;
        cpu_pulse();
        chk("step ignored: mar follows prog_addr", 32'(mar_q), 32'h2);
        chk("step ignored: no RAM write",          32'(ram_q), 32'h00);
        clear_bus();
        prog_write = 1'b1;
        clks(5);
        prog_mode = 1'b0;
        clks(20);
        chk("prog exit: led low",          32'(prog_mode_led), 32'h0);
        chk("prog exit: mar kept",         32'(mar_q),         32'h2);
        chk("prog exit: aborted no write", 32'(ram_q),         32'h00);
        chk("err_conflict sticky",         32'(err_conflict),  32'h1);
        prog_write = 1'b0;
        clks(4);

        // Reset clears RAM and sticky error
        rst = 1'b1;
        clks(3);
        rst = 1'b0;
        clks(3);
        chk("re-reset mar_q",        32'(mar_q),        32'h0);
        chk("re-reset err_conflict", 32'(err_conflict), 32'h0);
        for (int i = 7; i < 9; i++) run_row(i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
